// File: rtl/pe_pkg.sv
// Shared definitions for the multiply-accumulate processing element:
// FSM state encoding, default widths and a small width helper.
package pe_pkg;

    // Default operand / retained-product width.
    localparam int DEFAULT_PRECISION        = 8;
    // Default width of the partial-sum path.
    localparam int DEFAULT_OUTPUT_PRECISION = 32;

    // Control FSM states of the PE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } pe_state_e;

    // Width of a counter that must hold the values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pe_pkg

// File: rtl/pe_shift_add_mult.sv
// Sequential shift-add multiplier core: retires one multiplier bit per step.
// The product is kept to PRECISION bits, so it is (a*b) mod 2^PRECISION.
// acc_next exposes the accumulator value that the current step will write,
// so the owner can capture the final product on the same edge as the last step.
module pe_shift_add_mult
    import pe_pkg::*;
#(
    parameter int PRECISION = DEFAULT_PRECISION
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,       // capture operands, clear accumulator and count
    input  logic                 step,       // process one multiplier bit
    input  logic [PRECISION-1:0] a,          // multiplicand
    input  logic [PRECISION-1:0] b,          // multiplier
    output logic [PRECISION-1:0] acc_next,   // accumulator after the current step
    output logic                 last_step   // current step retires the final multiplier bit
);

    localparam int CNT_W = cnt_width(PRECISION);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRECISION - 1);

    logic [PRECISION-1:0] mcand_q,  mcand_d;
    logic [PRECISION-1:0] mplier_q, mplier_d;
    logic [PRECISION-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;

    // Partial-product add for the bit currently at the bottom of the multiplier.
    always_comb begin
        acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step = (cnt_q == LAST_CNT);
    end

    // Next-state of the datapath: load has priority over step.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path through the
        //       if/else leaves one unassigned and no latch is inferred.
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;   // bits shifted past the top are dropped: mod 2^PRECISION
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are a handful of flops, not a memory, so all of them are
        //       reset; an abort then leaves no stale operand behind.
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge
            //       values regardless of statement order.
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule : pe_shift_add_mult

// File: rtl/processing_element.sv
// Multiply-accumulate processing element: s_out = s_in + ((a_in*b_in) mod 2^PRECISION).
// Holds the control FSM, the partial-sum latch, the final adder and the
// registered outputs; the multiplication itself runs in pe_shift_add_mult.
// A request is taken only in IDLE; ready pulses for the single DONE cycle and
// s_out keeps its value until the next result is written.
module processing_element
    import pe_pkg::*;
#(
    parameter int PRECISION        = DEFAULT_PRECISION,
    parameter int OUTPUT_PRECISION = DEFAULT_OUTPUT_PRECISION
) (
    input  logic                        CLK,
    input  logic                        reset,          // asynchronous, active-low
    input  logic [PRECISION-1:0]        a_in,
    input  logic [PRECISION-1:0]        b_in,
    input  logic [OUTPUT_PRECISION-1:0] s_in,
    input  logic                        start_multiply,
    output logic [OUTPUT_PRECISION-1:0] s_out,
    output logic                        ready
);

    pe_state_e                   state_q, state_d;
    logic [OUTPUT_PRECISION-1:0] s_in_q,  s_in_d;
    logic [OUTPUT_PRECISION-1:0] s_out_q, s_out_d;
    logic                        ready_q, ready_d;

    logic                 mult_load;
    logic                 mult_step;
    logic [PRECISION-1:0] mult_acc_next;
    logic                 mult_last_step;

    pe_shift_add_mult #(
        .PRECISION (PRECISION)
    ) u_mult (
        .clk       (CLK),
        .rst_n     (reset),
        .load      (mult_load),
        .step      (mult_step),
        .a         (a_in),
        .b         (b_in),
        .acc_next  (mult_acc_next),
        .last_step (mult_last_step)
    );

    // FSM next-state, multiplier control and output register next values.
    always_comb begin
        state_d   = state_q;
        s_in_d    = s_in_q;
        s_out_d   = s_out_q;
        ready_d   = 1'b0;
        mult_load = 1'b0;
        mult_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_multiply) begin
                    mult_load = 1'b1;
                    s_in_d    = s_in;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                mult_step = 1'b1;
                if (mult_last_step) begin
                    // Product is zero-extended; the sum wraps at OUTPUT_PRECISION bits.
                    s_out_d = s_in_q + OUTPUT_PRECISION'(mult_acc_next);
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Unconditional return; inputs seen here are not used.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_in_q  <= '0;
            s_out_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_in_q  <= s_in_d;
            s_out_q <= s_out_d;
            ready_q <= ready_d;
        end
    end

    assign s_out = s_out_q;
    assign ready = ready_q;

endmodule : processing_element

// File: tb/tb_processing_element.sv
// Directed self-checking bench for processing_element (PRECISION=8, OUTPUT_PRECISION=32).
module tb_processing_element;

    localparam int P  = 8;
    localparam int OP = 32;

    logic          CLK;
    logic          reset;
    logic [P-1:0]  a_in;
    logic [P-1:0]  b_in;
    logic [OP-1:0] s_in;
    logic          start_multiply;
    logic [OP-1:0] s_out;
    logic          ready;

    int checks   = 0;
    int failures = 0;

    processing_element #(
        .PRECISION        (P),
        .OUTPUT_PRECISION (OP)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .a_in           (a_in),
        .b_in           (b_in),
        .s_in           (s_in),
        .start_multiply (start_multiply),
        .s_out          (s_out),
        .ready          (ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One operation from IDLE: request, scramble inputs after latching, wait for ready.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] s);
        logic [7:0]  prod;
        logic [31:0] exp_sum;
        logic [31:0] prev;
        int          lat;
        prod    = a * b;
        exp_sum = s + {24'd0, prod};
        prev    = s_out;
        a_in = a; b_in = b; s_in = s; start_multiply = 1'b1;
        tick();                                   // latching edge
        start_multiply = 1'b0;
        a_in = ~a; b_in = 8'hFF; s_in = 32'hDEAD_BEEF;
        lat = 0;
        while (!ready && lat < 40) begin
            if (lat == 4) check({tag, "_hold_mid_op"}, s_out, prev);
            tick();
            lat++;
        end
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_sum"}, s_out, exp_sum);
        tick();                                   // DONE -> IDLE
        check({tag, "_ready_single"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        logic [7:0]  a_v, b_v, prod;
        logic [31:0] s_v, exp_sum;
        int          lat, last_ready, pulses, edge_no, results;

        reset = 1'b0; start_multiply = 1'b0;
        a_in = '0; b_in = '0; s_in = '0;

        // Reset state.
        repeat (3) tick();
        check("reset_s_out", s_out, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);

        // Release reset with start already high: first ready after 9 edges.
        start_multiply = 1'b1;
        @(negedge CLK);
        reset = 1'b1;
        lat = 0;
        while (!ready && lat < 40) begin
            tick();
            lat++;
        end
        start_multiply = 1'b0;
        check("zero_ready", {31'd0, ready}, 32'd1);
        check("first_ready_latency", lat, 32'd9);
        check("zero_sum", s_out, 32'h0000_0000);
        tick();
        check("zero_ready_single", {31'd0, ready}, 32'd0);

        run_op("basic", 8'd5, 8'd7, 32'd2);                 // 35+2 = 0x25
        run_op("trunc", 8'd15, 8'd21, 32'd6);               // 315 mod 256 = 59, +6 = 0x41
        run_op("wrap", 8'd1, 8'd1, 32'hFFFF_FFFF);          // wraps to 0
        run_op("a_zero", 8'd0, 8'd200, 32'h1234_5678);      // result = s_in
        run_op("max", 8'hFF, 8'hFF, 32'h0000_0100);         // 0xFE01 mod 256 = 1 -> 0x101

        // Back-to-back with start held high; inputs stepped on each ready.
        a_v = 8'd3; b_v = 8'd4; s_v = 32'd100;
        a_in = a_v; b_in = b_v; s_in = s_v; start_multiply = 1'b1;
        results = 0; edge_no = 0; last_ready = -1;
        while (results < 10 && edge_no < 200) begin
            tick();
            edge_no++;
            if (ready) begin
                prod    = a_v * b_v;
                exp_sum = s_v + {24'd0, prod};
                check($sformatf("b2b_sum_%0d", results), s_out, exp_sum);
                if (last_ready >= 0)
                    check($sformatf("b2b_period_%0d", results), edge_no - last_ready, 32'd10);
                last_ready = edge_no;
                results++;
                a_v = a_v + 8'd5; b_v = b_v + 8'd7; s_v = s_v + 32'd2;
                a_in = a_v; b_in = b_v; s_in = s_v;
                tick();
                edge_no++;
                check($sformatf("b2b_ready_single_%0d", results), {31'd0, ready}, 32'd0);
            end
        end
        check("b2b_result_count", results, 32'd10);
        start_multiply = 1'b0;
        repeat (12) tick();

        // Reset asserted mid-BUSY aborts the operation.
        a_in = 8'd9; b_in = 8'd9; s_in = 32'h0000_1234; start_multiply = 1'b1;
        tick();                                   // latch
        start_multiply = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("abort_s_out", s_out, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        @(negedge CLK);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ready) pulses++;
        end
        check("abort_no_ready", pulses, 32'd0);
        check("abort_s_out_held", s_out, 32'd0);

        run_op("after_abort", 8'd2, 8'd3, 32'd1);           // 6+1 = 7

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_processing_element
